// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit add split into SEG_W-bit ripple segments, one register per segment.
// Define PIPELINED_RIPPLE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_ripple_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned STAGES = WIDTH / SEG_W;

  logic              en;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] ci;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  ps    [STAGES];
  logic [WIDTH-1:0]  ax    [STAGES];
  logic [WIDTH-1:0]  by    [STAGES];

  // The whole pipeline freezes only when a finished result is not being taken.
  assign en        = !(v_q[STAGES-1] && !out_ready);
  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

  assign ax[0] = x;
  assign by[0] = y;
  assign ci[0] = cin;
  assign ps[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_tap
    assign ci[k] = c_q[k-1];
    assign ps[k] = sum_q[k-1];
  end

  // Operand skew: stage k sees the operands accepted k cycles earlier.
  if (STAGES > 1) begin : g_skew
    logic [WIDTH-1:0] x_q [STAGES-1];
    logic [WIDTH-1:0] y_q [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < STAGES-1; k++) begin
          x_q[k] <= '0;
          y_q[k] <= '0;
        end
      end else if (en) begin
        for (int k = 0; k < STAGES-1; k++) begin
          x_q[k] <= ax[k];
          y_q[k] <= by[k];
        end
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_op
      assign ax[k] = x_q[k-1];
      assign by[k] = y_q[k-1];
    end
  end

  // Per-segment ripple of full-adder cells; lower sum segments ride along (deskew).
  always_comb begin
    logic a;
    logic b;
    logic c;
    a   = 1'b0;
    b   = 1'b0;
    c   = 1'b0;
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      c        = ci[k];
      sum_d[k] = ps[k];
      for (int i = 0; i < SEG_W; i++) begin
        a = ax[k][k*SEG_W + i];
        b = by[k][k*SEG_W + i];
        sum_d[k][k*SEG_W + i] = a ^ b ^ c;
        c = (a & b) | (a & c) | (b & c);
      end
      c_d[k] = c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
      end
    end
  end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  logic ovf_d;
  assign ovf_d = ax[STAGES-1][WIDTH-1] ^ by[STAGES-1][WIDTH-1]
               ^ sum_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (en) begin
      ovf <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: directed vectors, stream, stall, reset and segment sweep.
module tb_pipelined_ripple_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        cin = 1'b0;

  logic        in_ready, out_valid, cout;
  logic [15:0] s;
  logic        in_ready1, out_valid1, cout1;
  logic [15:0] s1;
  logic        in_ready16, out_valid16, cout16;
  logic [15:0] s16;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  logic        ovf, ovf1, ovf16;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(16), .SEG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_ripple_adder #(.WIDTH(16), .SEG_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .x(x), .y(y), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
    .s(s1), .cout(cout1)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  pipelined_ripple_adder #(.WIDTH(16), .SEG_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .x(x), .y(y), .cin(cin), .out_valid(out_valid16), .out_ready(out_ready),
    .s(s16), .cout(cout16)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  // Drive one beat and count cycles until the main instance shows out_valid (bounded).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
    x = a; y = b; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL reset_s: got %h expected 0000", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic;
    int lat;
    issue(16'h1234, 16'h4321, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (s !== 16'h5555) begin errors++; $display("FAIL basic_s: got %h expected 5555", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", cout); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_result: out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_full_carry;
    int lat;
    issue(16'hFFFF, 16'h0000, 1'b1, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL carry1_latency: got %0d expected 4", lat); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL carry1_s: got %h expected 0000", s); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry1_cout: got %b expected 1", cout); end
    issue(16'hFFFF, 16'hFFFF, 1'b1, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL carry2_latency: got %0d expected 4", lat); end
    checks++; if (s !== 16'hFFFF) begin errors++; $display("FAIL carry2_s: got %h expected ffff", s); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry2_cout: got %b expected 1", cout); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [16:0] q[$];
    int got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i < 100) begin
        in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 100) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", i, in_ready); end
      end
      if (in_valid && in_ready) q.push_back(17'(x) + 17'(y) + 17'(cin));
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got %h with nothing outstanding", {cout, s});
        end else begin
          if ({cout, s} !== q[0]) begin errors++; $display("FAIL b2b_result: #%0d got %h expected %h", got, {cout, s}, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++; if (got != 100) begin errors++; $display("FAIL b2b_count: got %0d expected 100", got); end
  endtask

  task automatic test_stall;
    logic [15:0] va[6] = '{16'h0001, 16'h8000, 16'h00FF, 16'h0F0F, 16'h1111, 16'hABCD};
    logic [15:0] vb[6] = '{16'h0002, 16'h8000, 16'h0001, 16'hF0F0, 16'h2222, 16'h1111};
    logic        vc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [16:0] ea[6] = '{17'h00003, 17'h10000, 17'h00100, 17'h10000, 17'h03334, 17'h0BCDE};
    int sent = 0;
    int got = 0;
    int stall_left = 3;
    logic [15:0] hs = '0;
    logic hc = 1'b0;
    for (int i = 0; i < 60 && got < 6; i++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin x = va[sent]; y = vb[sent]; cin = vc[sent]; end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left == 3) begin
          hs = s; hc = cout;
        end else begin
          checks++; if (s !== hs) begin errors++; $display("FAIL stall_s_frozen: got %h expected %h", s, hs); end
          checks++; if (cout !== hc) begin errors++; $display("FAIL stall_cout_frozen: got %b expected %b", cout, hc); end
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
        end
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if ({cout, s} !== ea[got]) begin errors++; $display("FAIL stall_result: #%0d got %h expected %h", got, {cout, s}, ea[got]); end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 6) begin errors++; $display("FAIL stall_count: got %0d expected 6", got); end
    checks++; if (stall_left != 0) begin errors++; $display("FAIL stall_applied: remaining %0d expected 0", stall_left); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_duplicate: out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = 16'(i + 5); y = 16'h0100; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL rstmid_s: got %h expected 0000", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rstmid_cout: got %b expected 0", cout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(16'h0001, 16'h0001, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
    checks++; if (s !== 16'h0002) begin errors++; $display("FAIL rstmid_s_after: got %h expected 0002", s); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale results expected 0", stale); end
  endtask

  task automatic test_ovf;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    int lat;
    issue(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos: got %b expected 1", ovf); end
    checks++; if (s !== 16'h8000) begin errors++; $display("FAIL ovf_pos_s: got %h expected 8000", s); end
    issue(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_neg: got %b expected 0", ovf); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf_neg_cout: got %b expected 1", cout); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_seg_sweep;
    logic [15:0] va[2] = '{16'hBEEF, 16'hFFFF};
    logic [15:0] vb[2] = '{16'h1234, 16'h0001};
    logic        vc[2] = '{1'b1, 1'b0};
    logic [16:0] ea[2] = '{17'h0D124, 17'h10000};
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    for (int v = 0; v < 2; v++) begin
      int l1 = 0;
      int l16 = 0;
      logic [16:0] r1 = '0;
      logic [16:0] r16 = '0;
      x = va[v]; y = vb[v]; cin = vc[v]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 24; n++) begin
        if (out_valid16 && l16 == 0) begin l16 = n; r16 = {cout16, s16}; end
        if (out_valid1 && l1 == 0) begin l1 = n; r1 = {cout1, s1}; end
        @(posedge clk); #1;
      end
      checks++; if (l16 != 1) begin errors++; $display("FAIL seg16_latency: vec %0d got %0d expected 1", v, l16); end
      checks++; if (r16 !== ea[v]) begin errors++; $display("FAIL seg16_result: vec %0d got %h expected %h", v, r16, ea[v]); end
      checks++; if (l1 != 16) begin errors++; $display("FAIL seg1_latency: vec %0d got %0d expected 16", v, l1); end
      checks++; if (r1 !== ea[v]) begin errors++; $display("FAIL seg1_result: vec %0d got %h expected %h", v, r1, ea[v]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_carry();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_ovf();
    test_seg_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
